// File: rtl/spi_regfile_if.sv
// spi_regfile_if: 4-wire SPI pin bundle between a controller and the register file.
interface spi_regfile_if;
    logic sclk;
    logic ncs;
    logic copi;
    logic cipo;
    logic cipo_oe;
    modport master (output sclk, ncs, copi, input cipo, cipo_oe);
    modport slave (input sclk, ncs, copi, output cipo, cipo_oe);
endinterface

// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 register file with write commit, CIPO readback and frame-error detection.
module spi_regfile #(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    spi_regfile_if.slave                 spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME_W + 1);

    logic [2:0] s1, s2;
    logic [1:0] sd;
    logic ncs_s, sclk_s, copi_s;
    logic ncs_fall, ncs_rise, sclk_rise, sclk_fall;
    logic [CNT_W-1:0] cnt;
    logic [FRAME_W-1:0] sr;
    logic ovf, full, wr_hit, commit, err, load;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_val, osr;
    logic [DATA_W-1:0] regs [NUM_REGS];

    // bit order {ncs, sclk, copi}; ncs idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 3'b100;
            s2 <= 3'b100;
            sd <= 2'b10;
        end else begin
            s1 <= {spi.ncs, spi.sclk, spi.copi};
            s2 <= s1;
            sd <= s2[2:1];
        end
    end

    assign ncs_s     = s2[2];
    assign sclk_s    = s2[1];
    assign copi_s    = s2[0];
    assign ncs_fall  = sd[1] & ~ncs_s;
    assign ncs_rise  = ~sd[1] & ncs_s;
    assign sclk_rise = ~sd[0] & sclk_s & ~ncs_s;
    assign sclk_fall = sd[0] & ~sclk_s & ~ncs_s;

    assign full   = cnt == CNT_W'(FRAME_W);
    assign addr   = sr[FRAME_W-2 -: ADDR_W];
    assign commit = ncs_rise & full & ~ovf & sr[FRAME_W-1] & wr_hit;
    assign err    = ncs_rise & ((cnt != '0 & ~full) | ovf);
    // the address LSB has just landed and the R/W bit sits right above it
    assign load   = sclk_fall & cnt == CNT_W'(1 + ADDR_W) & ~sr[ADDR_W];

    always_comb begin
        wr_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit = wr_hit | (addr == ADDR_W'(i));
            rd_val = (sr[ADDR_W-1:0] == ADDR_W'(i)) ? regs[i] : rd_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sr  <= '0;
            ovf <= 1'b0;
        end else if (ncs_fall || ncs_rise) begin
            cnt <= '0;
            sr  <= '0;
            ovf <= 1'b0;
        end else if (sclk_rise) begin
            if (full) begin
                ovf <= 1'b1;
            end else begin
                sr  <= {sr[FRAME_W-2:0], copi_s};
                cnt <= cnt + 1'b1;
            end
        end
    end

    // zeros shift in behind the data, so cipo returns to 0 after DATA_W bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osr <= '0;
        end else if (ncs_fall || ncs_rise) begin
            osr <= '0;
        end else if (load) begin
            osr <= rd_val;
        end else if (sclk_fall) begin
            osr <= osr << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (commit && addr == ADDR_W'(i)) regs[i] <= sr[DATA_W-1:0];
            wr_strobe <= commit;
            frame_err <= err;
            if (commit) wr_addr <= addr;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

    assign spi.cipo    = osr[DATA_W-1];
    assign spi.cipo_oe = ~ncs_s;
endmodule

// File: tb/tb_spi_regfile.sv
// tb_spi_regfile: randomized SPI frames against a register-array model, on a default and a 16x16 build.
module tb_spi_regfile;
    logic clk = 1'b0, rst_n = 1'b0;
    logic sclk = 1'b0, ncs = 1'b1, copi = 1'b0, sel = 1'b0;
    logic [39:0] r0;
    logic [255:0] r1;
    logic w0, w1, e0, e1, cipo_obs;
    logic [6:0] wa0, wa1;
    int sc[2], ec[2];
    int errors = 0, checks = 0;
    logic [15:0] mdl[2][16];
    logic [6:0] wexp[2];

    always #5 clk = ~clk;

    spi_regfile_if a();
    spi_regfile_if b();
    assign a.sclk = sclk;
    assign a.copi = copi;
    assign a.ncs  = sel ? 1'b1 : ncs;
    assign b.sclk = sclk;
    assign b.copi = copi;
    assign b.ncs  = sel ? ncs : 1'b1;
    assign cipo_obs = sel ? b.cipo : a.cipo;

    spi_regfile #(.NUM_REGS(5), .ADDR_W(7), .DATA_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .spi(a.slave), .regs_flat(r0),
        .wr_strobe(w0), .wr_addr(wa0), .frame_err(e0));
    spi_regfile #(.NUM_REGS(16), .ADDR_W(7), .DATA_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .spi(b.slave), .regs_flat(r1),
        .wr_strobe(w1), .wr_addr(wa1), .frame_err(e1));

    always @(posedge clk) begin
        if (w0) sc[0]++;
        if (w1) sc[1]++;
        if (e0) ec[0]++;
        if (e1) ec[1]++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) mdl[s][i] = '0;
            wexp[s] = '0;
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < 5; i++) check("reg_a", 64'(r0[i*8 +: 8]), 64'(mdl[0][i]));
        for (int i = 0; i < 16; i++) check("reg_b", 64'(r1[i*16 +: 16]), 64'(mdl[1][i]));
        check("wr_addr_a", 64'(wa0), 64'(wexp[0]));
        check("wr_addr_b", 64'(wa1), 64'(wexp[1]));
    endtask

    // n bits are clocked; a frame is valid only when n equals the frame width
    task automatic frame(input logic rw, input logic [6:0] ad, input logic [15:0] d, input int n, input bit raise);
        int s, dw, nr, fw, s0, e0c, bad, j;
        logic [15:0] dm, rd;
        logic [31:0] fr, v;
        bit ok;
        s = int'(sel);
        dw = s ? 16 : 8;
        nr = s ? 16 : 5;
        fw = 8 + dw;
        dm = s ? d : {8'h00, d[7:0]};
        fr = s ? 32'({rw, ad, dm}) : 32'({rw, ad, dm[7:0]});
        v = (n >= fw) ? ((fr << (n - fw)) | ($urandom & ((32'd1 << (n - fw)) - 1))) : (fr >> (fw - n));
        s0 = sc[s];
        e0c = ec[s];
        bad = 0;
        rd = '0;
        ncs = 1'b0;
        #50;
        for (int i = 0; i < n; i++) begin
            copi = v[n-1-i];
            #50;
            j = i - 8;
            if (!rw && j >= 0 && j < dw) rd[dw-1-j] = cipo_obs;
            else if (cipo_obs !== 1'b0) bad++;
            sclk = 1'b1;
            #50;
            sclk = 1'b0;
        end
        #50;
        if (raise) begin
            ncs = 1'b1;
            #120;
            ok = n == fw && rw && ad < 7'(nr);
            if (ok) begin
                mdl[s][ad[3:0]] = dm;
                wexp[s] = ad;
            end
            check("strobe", 64'(sc[s] - s0), 64'(ok));
            check("frame_err", 64'(ec[s] - e0c), 64'(n != 0 && n != fw));
            check("cipo_idle", 64'(bad), 64'd0);
            if (!rw && n >= fw) check("rdata", 64'(rd), (ad < 7'(nr)) ? 64'(mdl[s][ad[3:0]]) : 64'd0);
            check("cipo_oe", 64'({a.cipo_oe, b.cipo_oe}), 64'd0);
            check_regs();
            #40;
        end
    endtask

    initial begin
        int fw, nr, r, n;
        clear_model();
        #30;
        check("rst_regs", 64'(r0) | 64'(|r1), 64'd0);
        check("rst_oe", 64'({a.cipo_oe, b.cipo_oe}), 64'd0);
        check("rst_pulses", 64'({w0, w1, e0, e1}), 64'd0);
        check("rst_cipo", 64'({a.cipo, b.cipo}), 64'd0);
        check("rst_wa", 64'({wa0, wa1}), 64'd0);
        rst_n = 1'b1;
        #50;
        sel = 1'b0;
        frame(1'b1, 7'd0, 16'h00F0, 16, 1'b1);
        frame(1'b1, 7'd4, 16'h00AA, 16, 1'b1);
        frame(1'b1, 7'd3, 16'h0055, 16, 1'b1);
        frame(1'b0, 7'd3, 16'h0000, 16, 1'b1);
        frame(1'b1, 7'd5, 16'h0012, 16, 1'b1);
        frame(1'b0, 7'd5, 16'h0000, 16, 1'b1);
        frame(1'b1, 7'd1, 16'h0033, 12, 1'b1);
        frame(1'b1, 7'd1, 16'h0033, 17, 1'b1);
        frame(1'b1, 7'd2, 16'h00FF, 10, 1'b0);
        rst_n = 1'b0;
        ncs = 1'b1;
        clear_model();
        #20;
        check("midrst_regs", 64'(r0) | 64'(|r1), 64'd0);
        rst_n = 1'b1;
        #60;
        frame(1'b1, 7'd2, 16'h00FF, 16, 1'b1);
        sel = 1'b1;
        #60;
        frame(1'b1, 7'd15, 16'hBEEF, 24, 1'b1);
        frame(1'b0, 7'd15, 16'h0000, 24, 1'b1);
        check("beef_flat", 64'(r1[255:240]), 64'hBEEF);
        for (int k = 0; k < 100; k++) begin
            sel = 1'($urandom_range(0, 1));
            #60;
            fw = sel ? 24 : 16;
            nr = sel ? 16 : 5;
            r = $urandom_range(0, 9);
            n = (r < 7) ? fw : (r == 7) ? $urandom_range(1, fw - 1) : (r == 8) ? fw + $urandom_range(1, 3) : 0;
            frame(1'($urandom), 7'($urandom_range(0, nr + 2)), 16'($urandom), n, 1'b1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
